// File: rtl/lockin_pkg.sv
// Shared types and elaboration-time helpers for the lock-in demodulator:
// state encoding, clog2 and the quarter-wave-mirrored sine table generator.
package lockin_pkg;

    typedef enum logic [0:0] {
        WAIT_SYNC = 1'b0,
        ACCUM     = 1'b1
    } state_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Only the first quadrant is evaluated; the rest is mirrored so the table
    // is exactly antisymmetric and a DC input cancels to zero.
    function automatic int ref_sin_entry(input int q_ref, input int m, input int k);
        int  j;
        int  sgn;
        real amp;
        j   = k % m;
        sgn = 1;
        if (j >= m / 2) begin
            j   = j - m / 2;
            sgn = -1;
        end
        if (j > m / 4) j = m / 2 - j;
        amp = real'((1 << (q_ref - 1)) - 1);
        return sgn * int'($floor(amp * $sin(2.0 * PI * real'(j) / real'(m)) + 0.5));
    endfunction

endpackage

// File: rtl/lockin_ref_rom.sv
// Sine/cosine reference ROM: one table, two synchronous read ports, with the
// cosine port offset by a quarter period.
module lockin_ref_rom
    import lockin_pkg::*;
#(
    parameter int Q_ref = 16,
    parameter int M     = 16,
    parameter int AW    = clog2(M)
) (
    input  logic                    clk,
    input  logic [AW-1:0]           addr,
    output logic signed [Q_ref-1:0] sin_q,
    output logic signed [Q_ref-1:0] cos_q
);

    logic signed [Q_ref-1:0] tbl [M];
    logic [AW-1:0]           cos_addr;
    logic signed [Q_ref-1:0] sin_d;
    logic signed [Q_ref-1:0] cos_d;

    for (genvar i = 0; i < M; i++) begin : g_tbl
        assign tbl[i] = Q_ref'(ref_sin_entry(Q_ref, M, i));
    end

    always_comb begin
        cos_addr = (addr >= AW'(M - M / 4)) ? addr - AW'(M - M / 4) : addr + AW'(M / 4);
        sin_d    = tbl[addr];
        cos_d    = tbl[cos_addr];
    end

    always_ff @(posedge clk) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
    end

endmodule

// File: rtl/lockin_acumulador.sv
// Dual-phase lock-in accumulator: capture -> ROM read -> multiply -> accumulate,
// closing a block every M*N accepted samples with a one-cycle valid pulse.
module lockin_acumulador
    import lockin_pkg::*;
#(
    parameter int Q_in  = 24,
    parameter int Q_ref = 16,
    parameter int Q_out = 64,
    parameter int M     = 16,
    parameter int N     = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [Q_in-1:0]  sample_in,
    input  logic                    sample_valid,
    input  logic                    sync_in,
    output logic signed [Q_out-1:0] data_out_fase,
    output logic signed [Q_out-1:0] data_out_cuad,
    output logic                    data_out_valid,
    output logic                    busy
);

    localparam int K_W = clog2(M);
    localparam int N_W = (N > 1) ? clog2(N) : 1;
    localparam int P_W = Q_in + Q_ref;

    state_t                  state_q, state_d;
    logic [K_W-1:0]          k_q, k_d, k_cur, k0_q, k0_d;
    logic [N_W-1:0]          n_q, n_d, n_cur;
    logic                    accept, k_wrap, n_wrap;
    // Bit 0: captured sample, bit 1: ROM output stage, bit 2: product stage
    logic [2:0]              vld_q, vld_d, first_q, first_d, last_q, last_d;
    logic signed [Q_in-1:0]  smp0_q, smp0_d, smp1_q, smp1_d;
    logic signed [Q_ref-1:0] ref_sin, ref_cos;
    logic signed [P_W-1:0]   psin_q, psin_d, pcos_q, pcos_d;
    logic signed [Q_out-1:0] psin_ext, pcos_ext, base_sin, base_cos, sum_sin, sum_cos;
    logic signed [Q_out-1:0] acc_sin_q, acc_sin_d, acc_cos_q, acc_cos_d;
    logic signed [Q_out-1:0] fase_q, fase_d, cuad_q, cuad_d;
    logic                    valid_q, valid_d;

    lockin_ref_rom #(.Q_ref(Q_ref), .M(M), .AW(K_W)) u_rom (
        .clk   (clk),
        .addr  (k0_q),
        .sin_q (ref_sin),
        .cos_q (ref_cos)
    );

    always_comb begin
        // A sync on a valid sample makes it index 0 of a fresh block
        k_cur   = sync_in ? '0 : k_q;
        n_cur   = sync_in ? '0 : n_q;
        accept  = sample_valid && (sync_in || state_q == ACCUM);
        k_wrap  = (k_cur == K_W'(M - 1));
        n_wrap  = (n_cur == N_W'(N - 1));
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        if (accept) begin
            state_d = ACCUM;
            k_d     = k_wrap ? '0 : k_cur + 1'b1;
            n_d     = !k_wrap ? n_cur : (n_wrap ? '0 : n_cur + 1'b1);
        end

        k0_d    = k_cur;
        smp0_d  = sample_in;
        vld_d   = {vld_q[1:0], accept};
        first_d = {first_q[1:0], (k_cur == '0) && (n_cur == '0)};
        last_d  = {last_q[1:0], k_wrap && n_wrap};
        smp1_d  = smp0_q;
        psin_d  = P_W'(smp1_q) * P_W'(ref_sin);
        pcos_d  = P_W'(smp1_q) * P_W'(ref_cos);

        // The first product of a block overwrites whatever an aborted block left behind
        psin_ext = Q_out'(psin_q);
        pcos_ext = Q_out'(pcos_q);
        base_sin = first_q[2] ? Q_out'(0) : acc_sin_q;
        base_cos = first_q[2] ? Q_out'(0) : acc_cos_q;
        sum_sin  = base_sin + psin_ext;
        sum_cos  = base_cos + pcos_ext;

        acc_sin_d = acc_sin_q;
        acc_cos_d = acc_cos_q;
        fase_d    = fase_q;
        cuad_d    = cuad_q;
        valid_d   = 1'b0;
        if (vld_q[2]) begin
            if (last_q[2]) begin
                fase_d    = sum_sin;
                cuad_d    = sum_cos;
                acc_sin_d = '0;
                acc_cos_d = '0;
                valid_d   = 1'b1;
            end else begin
                acc_sin_d = sum_sin;
                acc_cos_d = sum_cos;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= WAIT_SYNC;
            k_q       <= '0;
            n_q       <= '0;
            k0_q      <= '0;
            vld_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            smp0_q    <= '0;
            smp1_q    <= '0;
            psin_q    <= '0;
            pcos_q    <= '0;
            acc_sin_q <= '0;
            acc_cos_q <= '0;
            fase_q    <= '0;
            cuad_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            k0_q      <= k0_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            psin_q    <= psin_d;
            pcos_q    <= pcos_d;
            acc_sin_q <= acc_sin_d;
            acc_cos_q <= acc_cos_d;
            fase_q    <= fase_d;
            cuad_q    <= cuad_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out_fase  = fase_q;
    assign data_out_cuad  = cuad_q;
    assign data_out_valid = valid_q;
    assign busy           = (state_q == ACCUM);

endmodule

// File: tb/tb_lockin_acumulador.sv
// Bench for lockin_acumulador: a block-level model (a queue of accepted samples
// summed against a directly computed sine table) predicts every result pulse.
module tb_lockin_acumulador;

    localparam int Q_IN  = 24;
    localparam int Q_REF = 16;
    localparam int Q_OUT = 64;
    localparam int M     = 16;
    localparam int N     = 8;
    localparam int BLK   = M * N;
    localparam int AS    = (1 << (Q_REF - 1)) - 1;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    sample_valid = 1'b0;
    logic                    sync_in = 1'b0;
    logic signed [Q_IN-1:0]  sample_in = '0;
    logic signed [Q_OUT-1:0] data_out_fase, data_out_cuad;
    logic                    data_out_valid, busy;

    typedef struct {
        int     cyc;
        longint f;
        longint c;
    } res_t;

    res_t   exp_q[$];
    res_t   obs_q[$];
    int     ref_sin[M];
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     m_synced = 1'b0;
    int     m_blk[$];
    longint last_f = 0;
    longint last_c = 0;

    lockin_acumulador #(.Q_in(Q_IN), .Q_ref(Q_REF), .Q_out(Q_OUT), .M(M), .N(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sync_in        (sync_in),
        .data_out_fase  (data_out_fase),
        .data_out_cuad  (data_out_cuad),
        .data_out_valid (data_out_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (data_out_valid) obs_q.push_back(res_t'{cyc, data_out_fase, data_out_cuad});

    function automatic int ref_cos(input int k);
        return ref_sin[(k + M / 4) % M];
    endfunction

    function automatic int rnd_sample();
        logic [Q_IN-1:0] r;
        r = Q_IN'($urandom);
        return int'($signed(r));
    endfunction

    // Block model: accepted samples pile up in a queue; at M*N they are summed.
    function automatic void model_step(input bit s, input int x);
        longint f, c;
        if (!m_synced && !s) return;
        if (s) begin
            m_synced = 1'b1;
            m_blk.delete();
        end
        m_blk.push_back(x);
        if (m_blk.size() == BLK) begin
            f = 0;
            c = 0;
            foreach (m_blk[i]) begin
                f += longint'(m_blk[i]) * ref_sin[i % M];
                c += longint'(m_blk[i]) * ref_cos(i % M);
            end
            exp_q.push_back(res_t'{cyc + 4, f, c});
            last_f = f;
            last_c = c;
            m_blk.delete();
        end
    endfunction

    task automatic drive(input bit v, input bit s, input int x);
        @(negedge clk);
        sample_valid = v;
        sync_in      = s;
        sample_in    = Q_IN'(x);
        if (v) model_step(s, x);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (data_out_fase !== '0) begin errors++; $display("FAIL reset_fase: got %0d want 0", data_out_fase); end
        if (data_out_cuad !== '0) begin errors++; $display("FAIL reset_cuad: got %0d want 0", data_out_cuad); end
        if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, rnd_sample());
        idle(6);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_sync_busy: got %b want 0", busy); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL wait_sync_pulses: got %0d want 0", obs_q.size()); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_impulse();
        for (int i = 0; i < BLK; i++) drive(1'b1, i == 0, (i == 4) ? 1000 : 0);
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL impulse_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].f !== exp_q[i].f || obs_q[i].c !== exp_q[i].c) begin
                errors++;
                $display("FAIL impulse_result: cyc/fase/cuad got %0d/%0d/%0d want %0d/%0d/%0d",
                         obs_q[i].cyc, obs_q[i].f, obs_q[i].c, exp_q[i].cyc, exp_q[i].f, exp_q[i].c);
            end
        end
        checks += 3;
        if (data_out_fase !== 64'sd32767000) begin errors++; $display("FAIL impulse_fase: got %0d want 32767000", data_out_fase); end
        if (data_out_cuad !== '0) begin errors++; $display("FAIL impulse_cuad: got %0d want 0", data_out_cuad); end
        if (busy !== 1'b1) begin errors++; $display("FAIL impulse_busy: got %b want 1", busy); end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_dc();
        for (int i = 0; i < BLK; i++) drive(1'b1, i == 0, -500);
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL dc_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].f !== 0 || obs_q[i].c !== 0) begin
                errors++;
                $display("FAIL dc_result: cyc/fase/cuad got %0d/%0d/%0d want %0d/0/0",
                         obs_q[i].cyc, obs_q[i].f, obs_q[i].c, exp_q[i].cyc);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_matched();
        longint sq;
        sq = 0;
        for (int k = 0; k < M; k++) sq += longint'(ref_sin[k]) * ref_sin[k];
        for (int i = 0; i < BLK; i++) drive(1'b1, i == 0, ref_sin[i % M]);
        for (int i = 0; i < BLK; i++) drive(1'b1, 1'b0, ref_cos(i % M));
        idle(6);
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL matched_count: got %0d want 2", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].f !== ((i == 0) ? N * sq : 0) ||
                obs_q[i].c !== ((i == 0) ? 0 : N * sq)) begin
                errors++;
                $display("FAIL matched_result%0d: cyc/fase/cuad got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         obs_q[i].cyc, obs_q[i].f, obs_q[i].c, exp_q[i].cyc,
                         (i == 0) ? N * sq : 0, (i == 0) ? 0 : N * sq);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int     cnt;
        int     x;
        longint b1_f, b1_c;
        cnt = 0;
        while (cnt < BLK) begin
            if ($urandom_range(0, 99) < 30) begin
                drive(1'b1, cnt == 0, rnd_sample());
                cnt++;
            end else begin
                drive(1'b0, 1'($urandom_range(0, 1)), rnd_sample());
            end
        end
        b1_f = last_f;
        b1_c = last_c;
        for (int j = 0; j < BLK; j++) begin
            case ($urandom_range(0, 2))
                0:       x = -(1 << (Q_IN - 1));
                1:       x = (1 << (Q_IN - 1)) - 1;
                default: x = rnd_sample();
            endcase
            drive(1'b1, 1'b0, x);
            if (j == 64) begin
                checks++;
                if (data_out_fase !== b1_f || data_out_cuad !== b1_c) begin
                    errors++;
                    $display("FAIL b2b_hold: fase/cuad got %0d/%0d want %0d/%0d", data_out_fase, data_out_cuad, b1_f, b1_c);
                end
            end
        end
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].f !== exp_q[i].f || obs_q[i].c !== exp_q[i].c) begin
                errors++;
                $display("FAIL b2b_result%0d: cyc/fase/cuad got %0d/%0d/%0d want %0d/%0d/%0d", i,
                         obs_q[i].cyc, obs_q[i].f, obs_q[i].c, exp_q[i].cyc, exp_q[i].f, exp_q[i].c);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_resync();
        for (int i = 0; i < 50; i++) drive(1'b1, i == 0, (i == 4) ? 1000 : rnd_sample());
        for (int j = 0; j < BLK; j++) drive(1'b1, j == 0, rnd_sample());
        idle(6);
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL resync_count: got %0d want 1 (model %0d)", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].f !== exp_q[i].f || obs_q[i].c !== exp_q[i].c) begin
                errors++;
                $display("FAIL resync_result: cyc/fase/cuad got %0d/%0d/%0d want %0d/%0d/%0d",
                         obs_q[i].cyc, obs_q[i].f, obs_q[i].c, exp_q[i].cyc, exp_q[i].f, exp_q[i].c);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 70; i++) drive(1'b1, i == 0, rnd_sample());
        @(negedge clk);
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sync_in      = 1'b0;
        m_synced     = 1'b0;
        m_blk.delete();
        last_f = 0;
        last_c = 0;
        @(negedge clk);
        checks += 4;
        if (data_out_fase !== '0) begin errors++; $display("FAIL midreset_fase: got %0d want 0", data_out_fase); end
        if (data_out_cuad !== '0) begin errors++; $display("FAIL midreset_cuad: got %0d want 0", data_out_cuad); end
        if (data_out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", data_out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, rnd_sample());
        idle(4);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_wait: busy got %b want 0", busy); end
        for (int j = 0; j < BLK; j++) drive(1'b1, j == 0, rnd_sample());
        idle(6);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i].cyc !== exp_q[i].cyc || obs_q[i].f !== exp_q[i].f || obs_q[i].c !== exp_q[i].c) begin
                errors++;
                $display("FAIL midreset_result: cyc/fase/cuad got %0d/%0d/%0d want %0d/%0d/%0d",
                         obs_q[i].cyc, obs_q[i].f, obs_q[i].c, exp_q[i].cyc, exp_q[i].f, exp_q[i].c);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        for (int k = 0; k < M; k++) begin
            real x;
            x = real'(AS) * $sin(2.0 * 3.141592653589793 * real'(k) / real'(M));
            ref_sin[k] = (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(0.5 - x));
        end
        test_reset();
        test_impulse();
        test_dc();
        test_matched();
        test_back_to_back();
        test_resync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
